up_sampler: RTL and testbench

// - 2x nearest-neighbour upsampler, the return path of the downsampler.
// - Walks the DST_W x DST_H destination raster in row-major order and issues read addresses into the small source image buffer.
// - Writes each fetched pixel into the full-size output image buffer, so every source pixel lands on a 2x2 block.
// - Sits between the downsampled buffer (sync-read RAM) and the display/output buffer (sync-write RAM).

---
 rtl/img_pkg.sv | 23 ++
 rtl/raster_counter.sv | 45 ++++
 rtl/up_sampler.sv | 123 ++++++++++++
 tb/tb_up_sampler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | img_pkg: image geometry, bus widths and sequencer state encoding |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package img_pkg;

  localparam int IMG_W   = 100;
  localparam int IMG_H   = 75;
  localparam int IMG_LEN = IMG_W * IMG_H;
  localparam int ADDR_W  = 13;
  localparam int PIX_W   = 8;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | raster_counter: row-major x/y walker with clear, enable, last    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module raster_counter
  import img_pkg::*;
#(
  parameter int W  = IMG_W,
  parameter int H  = IMG_H,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  localparam logic [CW-1:0] C_X_MAX = CW'(W - 1);
  localparam logic [CW-1:0] C_Y_MAX = CW'(H - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == C_X_MAX) begin
        x <= '0;
        y <= (y == C_Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == C_X_MAX) && (y == C_Y_MAX);

endmodule
`default_nettype wire

// File: rtl/up_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | up_sampler: 2x nearest-neighbour upsampler, source RAM -> raster |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module up_sampler
  import img_pkg::*;
#(
  parameter int SRC_W = 50,
  parameter int SRC_H = 37,
  parameter int DST_W = IMG_W,
  parameter int DST_H = IMG_H,
  parameter int AW    = ADDR_W,
  parameter int DW    = PIX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_en,
  output logic          busy,
  output logic          done
);

  localparam logic [CNT_W-1:0] C_YS_MAX = CNT_W'(SRC_H - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  w_x;
  logic [CNT_W-1:0]  w_y;
  logic              w_last;
  logic              w_run;
  logic [CNT_W-1:0]  w_yh;
  logic [CNT_W-1:0]  w_ys;
  logic [AW-1:0]     w_src_addr;
  logic [AW-1:0]     w_dst_addr;
  logic              r_v1;
  logic              r_v2;
  logic [AW-1:0]     r_dst1;
  logic [AW-1:0]     r_dst2;

  assign w_run = (r_state == RUN);

  raster_counter #(
    .W  (DST_W),
    .H  (DST_H),
    .CW (CNT_W)
  ) u_raster (
    .clk   (clk),
    .rst   (rst),
    .en    (w_run),
    .clear (r_state == IDLE),
    .x     (w_x),
    .y     (w_y),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // FLUSH lasts until the final pixel has been written, so DONE never overlaps a write.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (!(r_v1 || r_v2 || wr_en)) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Source row clamps so the odd trailing destination row reuses the last source row.
  assign w_yh       = w_y >> 1;
  assign w_ys       = (w_yh > C_YS_MAX) ? C_YS_MAX : w_yh;
  assign w_src_addr = AW'(w_ys) * AW'(SRC_W) + AW'(w_x >> 1);
  assign w_dst_addr = AW'(w_y) * AW'(DST_W) + AW'(w_x);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
      r_v1    <= 1'b0;
      r_dst1  <= '0;
      r_v2    <= 1'b0;
      r_dst2  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      r_v1 <= w_run;
      if (w_run) begin
        rd_addr <= w_src_addr;
        r_dst1  <= w_dst_addr;
      end
      // Second meta stage matches the one-cycle RAM read latency.
      r_v2   <= r_v1;
      r_dst2 <= r_dst1;
      wr_en  <= r_v2;
      if (r_v2) begin
        wr_addr <= r_dst2;
        wr_data <= rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_up_sampler: random-gap frames against a raster reference model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_up_sampler;

  localparam int NPIX = 7500;
  localparam int NSRC = 1850;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:NSRC-1];
  int cap  [0:NPIX-1];
  int ref1 [0:NPIX-1];

  int cyc = 0;
  int rd_oob = 0;
  int n_wr, exp_addr, contig_err, busy_err, done_wr_err;
  int first_wr_cyc, first_wr_addr, last_wr_cyc, done_cyc;

  up_sampler dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural source buffer, one-cycle synchronous read.
  always @(posedge clk) begin
    if (rd_addr < 13'(NSRC)) rd_data <= mem[rd_addr];
    else begin
      rd_data <= 8'h00;
      rd_oob  <= rd_oob + 1;
    end
  end

  always @(negedge clk) begin
    if (wr_en) begin
      if (n_wr == 0) begin
        first_wr_cyc  = cyc;
        first_wr_addr = int'(wr_addr);
      end
      last_wr_cyc = cyc;
      if (int'(wr_addr) != exp_addr) contig_err++;
      if (!busy) busy_err++;
      if (done) done_wr_err++;
      if (wr_addr < 13'(NPIX)) cap[wr_addr] = int'(wr_data);
      exp_addr++;
      n_wr++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: destination (x,y) shows source (min(y/2, 36), x/2).
  function automatic int model_pix(input int a);
    int x, y, ys;
    x  = a % 100;
    y  = a / 100;
    ys = y / 2;
    if (ys > 36) ys = 36;
    return int'(mem[ys * 50 + x / 2]);
  endfunction

  task automatic clear_frame();
    n_wr = 0; exp_addr = 0; contig_err = 0; busy_err = 0; done_wr_err = 0;
    first_wr_cyc = -1; first_wr_addr = -1; last_wr_cyc = -1; done_cyc = -1;
    for (int i = 0; i < NPIX; i++) cap[i] = -1;
  endtask

  task automatic launch(output int start_cyc);
    clear_frame();
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic run_frame(input string name);
    int sc, k, perr;
    launch(sc);
    k = 0;
    while (done_cyc < 0 && k < 8000) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk({name, "_done_seen"}, int'(done_cyc >= 0), 1);
    chk({name, "_writes"}, n_wr, NPIX);
    chk({name, "_contig_err"}, contig_err, 0);
    chk({name, "_first_addr"}, first_wr_addr, 0);
    chk({name, "_busy_err"}, busy_err, 0);
    chk({name, "_done_during_wr"}, done_wr_err, 0);
    chk({name, "_first_lat"}, first_wr_cyc - (sc + 1), 3);
    chk({name, "_done_lat"}, done_cyc - last_wr_cyc, 2);
    perr = 0;
    for (int i = 0; i < NPIX; i++) if (cap[i] != model_pix(i)) perr++;
    chk({name, "_pixel_err"}, perr, 0);
  endtask

  task automatic release_start();
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic abort_at(input int pix, input string name);
    int sc, k;
    launch(sc);
    k = 0;
    while (n_wr < pix && k < 8000) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_reached"}, int'(n_wr >= pix), 1);
    #1 rst = 1'b0;
    #1;
    chk({name, "_wr_en"}, int'(wr_en), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_wr_addr"}, int'(wr_addr), 0);
    chk({name, "_rd_addr"}, int'(rd_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    int n0, diff;
    for (int i = 0; i < NSRC; i++) mem[i] = 8'(i);
    clear_frame();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    run_frame("f1");
    chk("rep_0", cap[0], 0);
    chk("rep_1", cap[1], 0);
    chk("rep_100", cap[100], 0);
    chk("rep_101", cap[101], 0);
    chk("rep_2", cap[2], 1);
    chk("rep_7399", cap[7399], 'h39);
    chk("clamp_7410", cap[7410], 'h0D);
    for (int i = 0; i < NPIX; i++) ref1[i] = cap[i];

    n0 = n_wr;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("no_restart_writes", n_wr - n0, 0);
    chk("done_hold", int'(done), 1);
    release_start();
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);

    run_frame("f2");
    diff = 0;
    for (int i = 0; i < NPIX; i++) if (cap[i] != ref1[i]) diff++;
    chk("f2_vs_f1", diff, 0);
    release_start();

    abort_at(3000, "abort3000");
    for (int i = 0; i < NSRC; i++) mem[i] = 8'($urandom);
    run_frame("f3");
    release_start();

    abort_at(int'($urandom_range(1, NPIX - 1)), "abort_rand");
    run_frame("f4");
    release_start();

    chk("rd_addr_oob", rd_oob, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
